// File: rtl/usb_rx_bit_decoder.sv
// -----------------------------------------------------------------------------
// usb_rx_bit_decoder
//
// Receive front end for USB full speed. It synchronises D+/D-, recovers bit
// timing from line transitions, NRZI-decodes and unstuffs the bit stream, and
// reports end-of-packet and bit-stuffing errors. The downstream usb_rx block
// builds bytes and packets from the one-cycle strobes produced here.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per USB bit time (8 = 96 MHz / 12 Mbps).
//                 Must be even and >= 4.
//
// Ports
//   clk           in   system clock
//   n_rst         in   asynchronous active-low reset
//   dp            in   USB D+ line (asynchronous to clk)
//   dm            in   USB D- line (asynchronous to clk)
//   rx_bit        out  decoded, unstuffed data bit; valid only with rx_bit_valid
//   rx_bit_valid  out  1-cycle strobe: rx_bit holds a new data bit
//   rx_eop        out  1-cycle strobe: end of packet (SE0, SE0, J) detected
//   rx_stuff_err  out  1-cycle strobe: seventh consecutive 1, or a broken EOP
//   rx_active     out  level: packet in progress (first K after idle until EOP)
//
// Configuration macro
//   USB_RX_INPUT_SYNC_EN  defined:   dp/dm each pass a 2-flop synchroniser,
//                                    adding 2 cycles of latency.
//                         undefined: dp/dm feed the line-state logic directly,
//                                    for benches that drive synchronous stimulus.
// -----------------------------------------------------------------------------
module usb_rx_bit_decoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic dp,
    input  logic dm,
    output logic rx_bit,
    output logic rx_bit_valid,
    output logic rx_eop,
    output logic rx_stuff_err,
    output logic rx_active
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(CLKS_PER_BIT / 2);

    // Line states, encoded as {dp, dm}. SE1 is folded into J by the decoder.
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;

    // Receive FSM states.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RECV  = 3'd1;
    localparam logic [2:0] ST_SE0_1 = 3'd2;
    localparam logic [2:0] ST_SE0_2 = 3'd3;
    localparam logic [2:0] ST_DROP  = 3'd4;

    // Six consecutive 1s force a stuffed 0 on the wire.
    localparam logic [2:0] ONES_MAX = 3'd6;

    // -------------------------------------------------------------------------
    // Input synchronisation
    // -------------------------------------------------------------------------
    logic dp_s;
    logic dm_s;

`ifdef USB_RX_INPUT_SYNC_EN
    logic [1:0] dp_sync_q;
    logic [1:0] dm_sync_q;

    // The synchronisers reset to an idle J so that releasing reset on an idle
    // bus does not look like a line transition.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_sync_q <= 2'b11;
            dm_sync_q <= 2'b00;
        end else begin
            dp_sync_q <= {dp_sync_q[0], dp};
            dm_sync_q <= {dm_sync_q[0], dm};
        end
    end

    assign dp_s = dp_sync_q[1];
    assign dm_s = dm_sync_q[1];
`else
    assign dp_s = dp;
    assign dm_s = dm;
`endif

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [1:0]       line_q,       line_d;        // line state seen last cycle
    logic [CNT_W-1:0] cnt_q,        cnt_d;         // bit timer
    logic [2:0]       state_q,      state_d;
    logic [1:0]       prev_level_q, prev_level_d;  // NRZI reference level (J/K)
    logic [2:0]       ones_q,       ones_d;        // consecutive decoded 1s
    logic             rx_bit_q,     rx_bit_d;
    logic             bit_valid_q,  bit_valid_d;
    logic             eop_q,        eop_d;
    logic             stuff_err_q,  stuff_err_d;
    logic             active_q,     active_d;

    // -------------------------------------------------------------------------
    // Line-state decode and bit timing
    // -------------------------------------------------------------------------
    logic [1:0] line_now;
    logic       transition;
    logic       sample_stb;
    logic       decoded_bit;
    logic       sample_se0;

    always_comb begin
        unique case ({dp_s, dm_s})
            2'b00:   line_now = LS_SE0;
            2'b01:   line_now = LS_K;
            default: line_now = LS_J;   // 2'b10 is J; SE1 (2'b11) is treated as J
        endcase
    end

    assign transition = (line_now != line_q);

    // A transition realigns the timer, so it must never also sample: the
    // sample point is always half a bit time after the most recent edge.
    assign sample_stb  = !transition && (cnt_q == SAMPLE_AT);
    assign sample_se0  = (line_now == LS_SE0);

    // NRZI: no change of level is a 1, a change of level is a 0.
    assign decoded_bit = (line_now == prev_level_q);

    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        if (transition) begin
            cnt_d = '0;
        end
    end

    assign line_d = line_now;

    // -------------------------------------------------------------------------
    // Receive FSM, NRZI decode and bit unstuffing
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case statement,
    // so no path can leave a value unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        prev_level_d = prev_level_q;
        ones_d       = ones_q;
        rx_bit_d     = 1'b0;
        bit_valid_d  = 1'b0;
        eop_d        = 1'b0;
        stuff_err_d  = 1'b0;
        active_d     = active_q;

        unique case (state_q)
            ST_IDLE: begin
                // Start of packet is the first J->K edge on an idle bus. SE0
                // on an idle bus (bus reset) is deliberately ignored.
                if (transition && (line_q == LS_J) && (line_now == LS_K)) begin
                    active_d     = 1'b1;
                    prev_level_d = LS_J;
                    ones_d       = '0;
                    state_d      = ST_RECV;
                end
            end

            ST_RECV: begin
                if (sample_stb) begin
                    if (sample_se0) begin
                        state_d = ST_SE0_1;
                    end else begin
                        prev_level_d = line_now;
                        if (decoded_bit) begin
                            if (ones_q == ONES_MAX) begin
                                // A seventh 1 can only be a corrupted packet.
                                stuff_err_d = 1'b1;
                                state_d     = ST_DROP;
                            end else begin
                                rx_bit_d    = 1'b1;
                                bit_valid_d = 1'b1;
                                ones_d      = ones_q + 3'd1;
                            end
                        end else begin
                            // A 0 after six 1s is the transmitter's stuffed
                            // bit and carries no data.
                            if (ones_q != ONES_MAX) begin
                                rx_bit_d    = 1'b0;
                                bit_valid_d = 1'b1;
                            end
                            ones_d = '0;
                        end
                    end
                end
            end

            ST_SE0_1: begin
                if (sample_stb) begin
                    if (sample_se0) begin
                        state_d = ST_SE0_2;
                    end else begin
                        // A single SE0 bit is not a legal EOP.
                        stuff_err_d = 1'b1;
                        state_d     = ST_DROP;
                    end
                end
            end

            ST_SE0_2: begin
                if (sample_stb) begin
                    if (line_now == LS_J) begin
                        eop_d    = 1'b1;
                        active_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else if (line_now == LS_K) begin
                        stuff_err_d = 1'b1;
                        state_d     = ST_DROP;
                    end
                    // A longer SE0 stays here until the closing J arrives.
                end
            end

            ST_DROP: begin
                // Bits are discarded until the packet closes with an EOP;
                // rx_active stays high so usb_rx sees one bounded packet.
                if (sample_stb && sample_se0) begin
                    state_d = ST_SE0_1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so that every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            line_q       <= LS_J;
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
            prev_level_q <= LS_J;
            ones_q       <= '0;
            rx_bit_q     <= 1'b0;
            bit_valid_q  <= 1'b0;
            eop_q        <= 1'b0;
            stuff_err_q  <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            line_q       <= line_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            prev_level_q <= prev_level_d;
            ones_q       <= ones_d;
            rx_bit_q     <= rx_bit_d;
            bit_valid_q  <= bit_valid_d;
            eop_q        <= eop_d;
            stuff_err_q  <= stuff_err_d;
            active_q     <= active_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rx_bit       = rx_bit_q;
    assign rx_bit_valid = bit_valid_q;
    assign rx_eop       = eop_q;
    assign rx_stuff_err = stuff_err_q;
    assign rx_active    = active_q;

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_bit_decoder
//
// Self-checking bench for usb_rx_bit_decoder. Packets are described as lists
// of line symbols, one per bit time; a reference model walks that list with
// the decoding rules (NRZI, unstuffing, EOP) and predicts the event stream,
// which is compared with the strobes the DUT produces.
// Event codes: 0/1 data bit, 2 stuff error, 3 end of packet.
// -----------------------------------------------------------------------------
module tb_usb_rx_bit_decoder;

    localparam int CPB = 8;

    localparam int SYM_J   = 0;
    localparam int SYM_K   = 1;
    localparam int SYM_SE0 = 2;
    localparam int SYM_SE1 = 3;

    localparam int EV_ERR = 2;
    localparam int EV_EOP = 3;

`ifdef USB_RX_INPUT_SYNC_EN
    localparam int LAT = CPB / 2 + 4;
`else
    localparam int LAT = CPB / 2 + 2;
`endif

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    logic dp    = 1'b1;
    logic dm    = 1'b0;
    logic rx_bit;
    logic rx_bit_valid;
    logic rx_eop;
    logic rx_stuff_err;
    logic rx_active;

    usb_rx_bit_decoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .dp           (dp),
        .dm           (dm),
        .rx_bit       (rx_bit),
        .rx_bit_valid (rx_bit_valid),
        .rx_eop       (rx_eop),
        .rx_stuff_err (rx_stuff_err),
        .rx_active    (rx_active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int sym_q[$];
    int exp_q[$];
    int got_q[$];
    int multi_strobe    = 0;
    int first_valid_cyc = -1;
    int mark_idx        = -1;
    int mark_cyc        = 0;

    int cur_level;
    int enc_ones;
    bit stuff_mode;

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (n_rst) begin
            if ((int'(rx_bit_valid) + int'(rx_eop) + int'(rx_stuff_err)) > 1)
                multi_strobe <= multi_strobe + 1;
            if (rx_bit_valid) begin
                got_q.push_back(int'(rx_bit));
                if (first_valid_cyc < 0) first_valid_cyc <= cyc;
            end
            if (rx_stuff_err) got_q.push_back(EV_ERR);
            if (rx_eop)       got_q.push_back(EV_EOP);
        end
    end

    // ---------------------------------------------------------------- checker
    task automatic check(input string tag, input integer obs, input integer exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- packet builders
    function automatic void push_sym(int s, int n);
        for (int i = 0; i < n; i++) sym_q.push_back(s);
    endfunction

    function automatic void push_sync();
        push_sym(SYM_K, 1); push_sym(SYM_J, 1); push_sym(SYM_K, 1); push_sym(SYM_J, 1);
        push_sym(SYM_K, 1); push_sym(SYM_J, 1); push_sym(SYM_K, 2);
        cur_level = SYM_K;
        enc_ones  = 1;          // the last SYNC bit is a 1
    endfunction

    function automatic void push_bit(int b);
        if (b == 0) cur_level = (cur_level == SYM_J) ? SYM_K : SYM_J;
        sym_q.push_back(cur_level);
    endfunction

    // In stuff_mode the encoder inserts a 0 after six 1s, as a real transmitter does.
    function automatic void push_data(int b);
        push_bit(b);
        if (stuff_mode) begin
            enc_ones = (b != 0) ? enc_ones + 1 : 0;
            if (enc_ones == 6) begin
                push_bit(0);
                enc_ones = 0;
            end
        end
    endfunction

    function automatic void start_packet();
        sym_q.delete();
        push_sym(SYM_J, 2);
        push_sync();
    endfunction

    function automatic void end_packet();
        push_sym(SYM_SE0, 2);
        push_sym(SYM_J, 3);
    endfunction

    // ---------------------------------------------------------------- reference model
    function automatic void run_model();
        bit in_pkt  = 0;
        bit dropped = 0;
        int se0_run = 0;
        int ones    = 0;
        int prev    = SYM_J;
        int ref_lvl = SYM_J;
        int s;
        exp_q.delete();
        foreach (sym_q[i]) begin
            s = (sym_q[i] == SYM_SE1) ? SYM_J : sym_q[i];
            if (!in_pkt && prev == SYM_J && s == SYM_K) begin
                in_pkt = 1; dropped = 0; se0_run = 0; ones = 0; ref_lvl = SYM_J;
            end
            if (in_pkt) begin
                if (s == SYM_SE0) begin
                    se0_run = (se0_run < 2) ? se0_run + 1 : 2;
                end else if (se0_run > 0) begin
                    if (se0_run == 2 && s == SYM_J) begin
                        exp_q.push_back(EV_EOP);
                        in_pkt = 0;
                    end else begin
                        exp_q.push_back(EV_ERR);
                        dropped = 1;
                    end
                    se0_run = 0;
                end else if (!dropped) begin
                    if (s == ref_lvl) begin
                        if (ones == 6) begin
                            exp_q.push_back(EV_ERR);
                            dropped = 1;
                        end else begin
                            exp_q.push_back(1);
                            ones++;
                        end
                    end else begin
                        if (ones != 6) exp_q.push_back(0);
                        ones = 0;
                    end
                    ref_lvl = s;
                end
            end
            prev = s;
        end
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic drive(input int s, input int len);
        case (s)
            SYM_J:   begin dp = 1'b1; dm = 1'b0; end
            SYM_K:   begin dp = 1'b0; dm = 1'b1; end
            SYM_SE0: begin dp = 1'b0; dm = 1'b0; end
            default: begin dp = 1'b1; dm = 1'b1; end
        endcase
        repeat (len) @(posedge clk);
        #1;
    endtask

    // Jittered playback alternates bit times one cycle short and one long.
    task automatic play(input int lo, input int hi, input bit jitter);
        int len;
        for (int i = lo; i < hi; i++) begin
            len = jitter ? (((i % 2) != 0) ? CPB + 1 : CPB - 1) : CPB;
            if (i == mark_idx) mark_cyc = cyc;
            drive(sym_q[i], len);
        end
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_event"}, (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
        check({tag, "_active_end"}, rx_active, 0);
    endtask

    task automatic run_packet(input string tag, input bit jitter);
        run_model();
        got_q.delete();
        play(0, sym_q.size(), jitter);
        compare_events(tag);
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    int n_err;
    int sync_exp[8];

    initial begin
        sync_exp = '{0, 0, 0, 0, 0, 0, 0, 1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_bit",    rx_bit,       0);
        check("rst_valid",  rx_bit_valid, 0);
        check("rst_eop",    rx_eop,       0);
        check("rst_err",    rx_stuff_err, 0);
        check("rst_active", rx_active,    0);
        n_rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // SYNC, latency, active level, then five 1s, a stuffed 0 and data.
        stuff_mode = 0;
        start_packet();
        for (int i = 0; i < 5; i++) push_data(1);
        push_data(0); push_data(0); push_data(1); push_data(0);
        end_packet();
        run_model();
        got_q.delete();
        first_valid_cyc = -1;
        mark_idx = 2;
        play(0, 10, 0);
        check("sync_active", rx_active, 1);
        play(10, sym_q.size(), 0);
        mark_idx = -1;
        check("sync_latency", first_valid_cyc - mark_cyc, LAT);
        for (int i = 0; i < 8; i++)
            check("sync_bits", (i < got_q.size()) ? got_q[i] : -1, sync_exp[i]);
        compare_events("unstuff");

        // Seventh consecutive 1 (the SYNC's final 1 plus six held bits).
        start_packet();
        for (int i = 0; i < 6; i++) push_data(1);
        push_data(0); push_data(1); push_data(0);
        end_packet();
        run_packet("stuff_err", 0);
        n_err = 0;
        foreach (got_q[i]) if (got_q[i] == EV_ERR) n_err++;
        check("stuff_err_pulses", n_err, 1);

        // Idle SE0 and SE1 before the packet must be ignored.
        sym_q.delete();
        push_sym(SYM_J, 1); push_sym(SYM_SE0, 2); push_sym(SYM_J, 1);
        push_sym(SYM_SE1, 1); push_sym(SYM_J, 2);
        push_sync();
        push_data(1); push_data(0); push_data(0);
        end_packet();
        run_packet("idle_se0", 0);

        // Single SE0 inside a packet, then a long SE0 before the closing J.
        start_packet();
        push_data(0); push_sym(SYM_SE0, 1); push_data(1); push_data(0);
        push_sym(SYM_SE0, 3); push_sym(SYM_J, 2);
        run_packet("short_se0", 0);

        // Jitter on clean, properly stuffed data.
        stuff_mode = 1;
        start_packet();
        for (int i = 0; i < 40; i++) push_data(($urandom_range(0, 3) != 0) ? 1 : 0);
        end_packet();
        run_packet("jitter", 1);

        // Asynchronous reset in the middle of a packet.
        start_packet();
        for (int i = 0; i < 10; i++) push_data(int'($urandom_range(0, 1)));
        end_packet();
        play(0, 14, 0);
        check("midrst_active_before", rx_active, 1);
        #3;
        n_rst = 1'b0;
        #1;
        check("midrst_bit",    rx_bit,       0);
        check("midrst_valid",  rx_bit_valid, 0);
        check("midrst_eop",    rx_eop,       0);
        check("midrst_err",    rx_stuff_err, 0);
        check("midrst_active", rx_active,    0);
        dp = 1'b1;
        dm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start_packet();
        for (int i = 0; i < 16; i++) push_data(int'($urandom_range(0, 1)));
        end_packet();
        run_packet("after_rst", 0);

        // Randomised packets: raw or stuffed data, optional SE0 glitch, jitter.
        for (int p = 0; p < 12; p++) begin
            int nbits;
            int glitch_at;
            stuff_mode = ($urandom_range(0, 1) != 0);
            nbits      = int'($urandom_range(4, 40));
            glitch_at  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            start_packet();
            for (int i = 0; i < nbits; i++) begin
                if (i == glitch_at) push_sym(SYM_SE0, 1);
                push_data(($urandom_range(0, 3) != 0) ? 1 : 0);
            end
            end_packet();
            run_packet($sformatf("rand%0d", p), ($urandom_range(0, 1) != 0));
        end

        check("one_strobe_per_cycle", multi_strobe, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
